// File: rtl/kcpsm6_rom_loader.sv
// kcpsm6_rom_loader
//
// Streams a program image into the PicoBlaze (KCPSM6) program ROM through
// its JTAG-loader port and reads every word back to verify it.
//
// Each program word arrives as three bytes on a valid/ready byte stream:
//   byte0[1:0] -> din[17:16]  (byte0[7:2] must be zero)
//   byte1      -> din[15:8]
//   byte2      -> din[7:0]
// Per word the loader issues one write cycle of jtag_clk (we=1), then one read
// cycle (we=0), and compares jtag_dout with the word just written.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, word_count load request and number of words (0 = nothing to do)
//   s_data/s_valid/s_ready  byte stream in
//   jtag_rst          holds the core in reset while its image is incomplete
//   jtag_en/clk/addr/din/we, jtag_dout  program-ROM loader port
//   busy, done, error, err_addr  status
//
// Every output is a register. The next-state logic computes the next value of
// each output alongside the next state, so outputs always line up with state.
module kcpsm6_rom_loader #(
  parameter int CLK_HALF = 2  // clk cycles per jtag_clk half-period, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] word_count,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        jtag_rst,
  output logic        jtag_en,
  output logic        jtag_clk,
  output logic [11:0] jtag_addr,
  output logic [17:0] jtag_din,
  output logic        jtag_we,
  input  logic [17:0] jtag_dout,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] err_addr
);

  localparam logic [3:0] PH_LAST = 4'(CLK_HALF - 1);

  typedef enum logic [3:0] {
    IDLE, RECV, WR_LO, WR_HI, RD_LO, RD_HI, CHECK, DONE, FAIL
  } state_t;

  state_t      state, state_n;
  logic [11:0] cnt, cnt_n;       // words in this load
  logic [1:0]  bcnt, bcnt_n;     // byte index within the current word
  logic [3:0]  ph, ph_n;         // cycles spent in the current jtag_clk phase

  logic        s_ready_n, jtag_rst_n, jtag_en_n, jtag_clk_n, jtag_we_n;
  logic [11:0] jtag_addr_n, err_addr_n;
  logic [17:0] jtag_din_n;
  logic        busy_n, done_n, error_n;
  logic        in_load;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bcnt_n      = bcnt;
    ph_n        = ph;
    jtag_addr_n = jtag_addr;
    jtag_din_n  = jtag_din;
    jtag_rst_n  = jtag_rst;
    err_addr_n  = err_addr;
    error_n     = error;
    done_n      = 1'b0;

    unique case (state)
      // DONE and FAIL last one cycle and behave like IDLE towards start,
      // since busy is already low while in them.
      IDLE, DONE, FAIL: begin
        state_n = IDLE;
        if (start) begin
          error_n = 1'b0;
          if (word_count == 12'd0) begin
            done_n = 1'b1;
          end else begin
            state_n     = RECV;
            cnt_n       = word_count;
            jtag_addr_n = 12'd0;
            bcnt_n      = 2'd0;
            jtag_rst_n  = 1'b1;
          end
        end
      end

      // The word is assembled straight into jtag_din; jtag_clk is low here so
      // the ROM never sees it half-built.
      RECV: begin
        if (s_valid && s_ready) begin
          unique case (bcnt)
            2'd0: begin
              if (s_data[7:2] != 6'd0) begin
                state_n    = FAIL;
                error_n    = 1'b1;
                err_addr_n = jtag_addr;
              end else begin
                jtag_din_n[17:16] = s_data[1:0];
                bcnt_n            = 2'd1;
              end
            end
            2'd1: begin
              jtag_din_n[15:8] = s_data;
              bcnt_n           = 2'd2;
            end
            default: begin
              jtag_din_n[7:0] = s_data;
              bcnt_n          = 2'd0;
              ph_n            = 4'd0;
              state_n         = WR_LO;
            end
          endcase
        end
      end

      WR_LO: begin
        if (ph == PH_LAST) begin
          ph_n    = 4'd0;
          state_n = WR_HI;
        end else begin
          ph_n = ph + 4'd1;
        end
      end

      // we drops on the same edge that returns jtag_clk low, never while high.
      WR_HI: begin
        if (ph == PH_LAST) begin
          ph_n    = 4'd0;
          state_n = RD_LO;
        end else begin
          ph_n = ph + 4'd1;
        end
      end

      RD_LO: begin
        if (ph == PH_LAST) begin
          ph_n    = 4'd0;
          state_n = RD_HI;
        end else begin
          ph_n = ph + 4'd1;
        end
      end

      RD_HI: begin
        if (ph == PH_LAST) begin
          ph_n    = 4'd0;
          state_n = CHECK;
        end else begin
          ph_n = ph + 4'd1;
        end
      end

      // jtag_dout was captured on the RD_HI rising edge and is stable now.
      CHECK: begin
        if (jtag_dout == jtag_din) begin
          jtag_addr_n = jtag_addr + 12'd1;  // wraps at 4096
          if (jtag_addr_n == cnt) begin
            state_n    = DONE;
            jtag_rst_n = 1'b0;  // full image verified: let the core run
          end else begin
            state_n = RECV;
          end
        end else begin
          state_n    = FAIL;
          error_n    = 1'b1;
          err_addr_n = jtag_addr;
        end
      end

      default: state_n = IDLE;
    endcase

    // Output decode from the next state; jtag_rst is left as set above so a
    // failed image keeps the core held until a later load completes.
    in_load    = (state_n == RECV)  || (state_n == WR_LO) || (state_n == WR_HI) ||
                 (state_n == RD_LO) || (state_n == RD_HI) || (state_n == CHECK);
    busy_n     = in_load;
    jtag_en_n  = in_load;
    s_ready_n  = (state_n == RECV);
    jtag_we_n  = (state_n == WR_LO) || (state_n == WR_HI);
    jtag_clk_n = (state_n == WR_HI) || (state_n == RD_HI);
    if (state_n == DONE) done_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 12'd0;
      bcnt      <= 2'd0;
      ph        <= 4'd0;
      s_ready   <= 1'b0;
      jtag_rst  <= 1'b0;
      jtag_en   <= 1'b0;
      jtag_clk  <= 1'b0;
      jtag_we   <= 1'b0;
      jtag_addr <= 12'd0;
      jtag_din  <= 18'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= 12'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bcnt      <= bcnt_n;
      ph        <= ph_n;
      s_ready   <= s_ready_n;
      jtag_rst  <= jtag_rst_n;
      jtag_en   <= jtag_en_n;
      jtag_clk  <= jtag_clk_n;
      jtag_we   <= jtag_we_n;
      jtag_addr <= jtag_addr_n;
      jtag_din  <= jtag_din_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      err_addr  <= err_addr_n;
    end
  end

endmodule

// File: tb/tb_kcpsm6_rom_loader.sv
// Bench for kcpsm6_rom_loader (CLK_HALF=3). A ROM model on the loader port
// records every write; expected writes are queued as bytes are scheduled and
// compared against the recorded writes when each load finishes. A negedge
// monitor measures jtag_clk phase lengths and port stability while high.
module tb_kcpsm6_rom_loader;
  localparam int CH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] word_count = 12'd0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready, jtag_rst, jtag_en, jtag_clk, jtag_we;
  logic [11:0] jtag_addr, err_addr;
  logic [17:0] jtag_din;
  logic [17:0] jtag_dout = 18'd0;
  logic        busy, done, error;

  always #5 clk = ~clk;

  kcpsm6_rom_loader #(.CLK_HALF(CH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .jtag_rst(jtag_rst), .jtag_en(jtag_en), .jtag_clk(jtag_clk),
    .jtag_addr(jtag_addr), .jtag_din(jtag_din), .jtag_we(jtag_we),
    .jtag_dout(jtag_dout), .busy(busy), .done(done), .error(error),
    .err_addr(err_addr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- ROM model ----------------
  logic [17:0] mem [4096];
  logic        corrupt_en = 1'b0;
  logic [11:0] corrupt_addr = 12'd0;
  logic [29:0] obs [256];
  int          wr_ptr = 0;

  always @(posedge jtag_clk) begin
    if (jtag_en) begin
      if (jtag_we) begin
        mem[jtag_addr]     <= jtag_din;
        obs[wr_ptr % 256]  <= {jtag_addr, jtag_din};
        wr_ptr             <= wr_ptr + 1;
      end else begin
        jtag_dout <= (corrupt_en && jtag_addr == corrupt_addr) ? 18'd0 : mem[jtag_addr];
      end
    end
  end

  // ---------------- phase / stability monitor ----------------
  logic        pclk = 1'b0, pwe = 1'b0;
  logic [11:0] paddr = 12'd0;
  logic [17:0] pdin = 18'd0;
  int hi_run = 0, lo_run = 0, wlo_run = 0;
  int hi_n = 0, hi_bad = 0, wlo_n = 0, wlo_bad = 0, rlo_n = 0, rlo_bad = 0;
  int stab_bad = 0, done_cnt = 0, rises = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pclk    <= 1'b0;
      hi_run  <= 0;
      lo_run  <= 0;
      wlo_run <= 0;
    end else begin
      pclk  <= jtag_clk;
      paddr <= jtag_addr;
      pdin  <= jtag_din;
      pwe   <= jtag_we;
      if (done) done_cnt <= done_cnt + 1;
      wlo_run <= (jtag_we && !jtag_clk) ? wlo_run + 1 : 0;
      if (jtag_clk) begin
        if (!pclk) begin
          rises  <= rises + 1;
          hi_run <= 1;
          if (jtag_we) begin
            wlo_n <= wlo_n + 1;
            if (wlo_run != CH) wlo_bad <= wlo_bad + 1;
          end else begin
            rlo_n <= rlo_n + 1;
            if (lo_run != CH) rlo_bad <= rlo_bad + 1;
          end
        end else begin
          hi_run <= hi_run + 1;
          if ({jtag_addr, jtag_din, jtag_we} !== {paddr, pdin, pwe}) stab_bad <= stab_bad + 1;
        end
      end else begin
        if (pclk) begin
          hi_n   <= hi_n + 1;
          if (hi_run != CH) hi_bad <= hi_bad + 1;
          lo_run <= 1;
        end else begin
          lo_run <= lo_run + 1;
        end
      end
    end
  end

  // ---------------- stimulus / scoreboard ----------------
  typedef struct {
    logic [11:0]       cnt;
    logic [3:0][17:0]  w;
    int                bad;      // word whose byte0 is 0x40, -1 none
    int                corrupt;  // address read back as 0, -1 none
    logic              eerr;
    logic [11:0]       eaddr;
    int                eacc;     // bytes expected to be consumed
  } vec_t;

  vec_t        vt [6];
  logic [29:0] sb [$];
  logic [7:0]  tx [$];
  int          rd_ptr = 0;

  function automatic vec_t mk(input logic [11:0] c, input logic [17:0] w0, input logic [17:0] w1,
                              input logic [17:0] w2, input logic [17:0] w3, input int bad,
                              input int cor, input logic ee, input logic [11:0] ea, input int acc);
    vec_t v;
    v.cnt = c; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.bad = bad; v.corrupt = cor; v.eerr = ee; v.eaddr = ea; v.eacc = acc;
    return v;
  endfunction

  task automatic drive_tx(input int maxcyc, output int acc);
    int  cyc;
    logic xfer;
    acc = 0; cyc = 0;
    while (acc < tx.size() && cyc < maxcyc) begin
      s_data  = tx[acc];
      s_valid = ($urandom_range(0, 3) != 0);
      xfer    = s_valid && s_ready;
      @(negedge clk);
      cyc++;
      if (xfer) acc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int cyc;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_writes(input string nm);
    chk({nm, "_nwrites"}, wr_ptr - rd_ptr, sb.size());
    while (sb.size() > 0 && rd_ptr < wr_ptr) begin
      chk({nm, "_write"}, {2'b0, obs[rd_ptr % 256]}, {2'b0, sb.pop_front()});
      rd_ptr++;
    end
    rd_ptr = wr_ptr;
    sb.delete();
  endtask

  task automatic run_vec(input string nm, input vec_t v, input bit busy_poke);
    int acc, nw, d0, h0, hb0, w0, wb0, r0, rb0, sb0;
    logic [11:0] ia;
    corrupt_en   = (v.corrupt >= 0);
    corrupt_addr = 12'(v.corrupt);
    tx.delete();
    for (int i = 0; i < int'(v.cnt); i++) begin
      ia = 12'(i);
      tx.push_back((i == v.bad) ? 8'h40 : {6'd0, v.w[i][17:16]});
      tx.push_back(v.w[i][15:8]);
      tx.push_back(v.w[i][7:0]);
      if (v.bad < 0 || i < v.bad) sb.push_back({ia, v.w[i]});
    end
    nw = (v.bad >= 0) ? v.bad : int'(v.cnt);
    d0 = done_cnt; h0 = hi_n; hb0 = hi_bad; w0 = wlo_n; wb0 = wlo_bad;
    r0 = rlo_n; rb0 = rlo_bad; sb0 = stab_bad;

    @(negedge clk);
    start = 1'b1; word_count = v.cnt;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_start_flags"}, {29'd0, busy, jtag_en, jtag_rst}, 32'd7);
    chk({nm, "_start_err"}, {31'd0, error}, 32'd0);
    chk({nm, "_start_addr"}, {20'd0, jtag_addr}, 32'd0);
    if (busy_poke) begin
      start = 1'b1; word_count = 12'd1;
      @(negedge clk);
      start = 1'b0;
    end

    drive_tx(300, acc);
    wait_idle({nm, "_idle_timeout"});
    repeat (3) @(negedge clk);

    chk({nm, "_accepted"}, acc, v.eacc);
    chk({nm, "_error"}, {31'd0, error}, {31'd0, v.eerr});
    if (v.eerr) chk({nm, "_err_addr"}, {20'd0, err_addr}, {20'd0, v.eaddr});
    else        chk({nm, "_end_addr"}, {20'd0, jtag_addr}, {20'd0, v.cnt});
    chk({nm, "_done_pulses"}, done_cnt - d0, v.eerr ? 0 : 1);
    chk({nm, "_jtag_rst"}, {31'd0, jtag_rst}, {31'd0, v.eerr});
    chk({nm, "_idle_outs"}, {28'd0, jtag_en, s_ready, jtag_we, jtag_clk}, 32'd0);
    chk({nm, "_hi_phases"}, hi_n - h0, 2 * nw);
    chk({nm, "_wr_phases"}, wlo_n - w0, nw);
    chk({nm, "_rd_phases"}, rlo_n - r0, nw);
    chk({nm, "_phase_len"}, (hi_bad - hb0) + (wlo_bad - wb0) + (rlo_bad - rb0), 0);
    chk({nm, "_stable_hi"}, stab_bad - sb0, 0);
    compare_writes(nm);
  endtask

  initial begin
    int acc, cyc, r0;
    vt[0] = mk(12'd2, 18'h12345, 18'h2ABCD, 18'h0, 18'h0, -1, -1, 1'b0, 12'd0, 6);
    vt[1] = mk(12'd2, 18'h12345, 18'h2ABCD, 18'h0, 18'h0, -1,  1, 1'b1, 12'd1, 6);
    vt[2] = mk(12'd3, 18'h3FFFF, 18'h00000, 18'h15555, 18'h0, 1, -1, 1'b1, 12'd1, 4);
    vt[3] = mk(12'd4, 18'h00001, 18'h20000, 18'h1FEDC, 18'h3A5A5, -1, -1, 1'b0, 12'd0, 12);
    vt[4] = mk(12'd1, 18'h20F0F, 18'h0, 18'h0, 18'h0, -1, 0, 1'b1, 12'd0, 3);
    vt[5] = mk(12'd1, 18'h11111, 18'h0, 18'h0, 18'h0, -1, -1, 1'b0, 12'd0, 3);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_flags", {24'd0, s_ready, jtag_rst, jtag_en, jtag_clk, jtag_we, busy, done, error}, 32'd0);
    chk("reset_addr", {20'd0, jtag_addr}, 32'd0);
    chk("reset_din", {14'd0, jtag_din}, 32'd0);
    chk("reset_err_addr", {20'd0, err_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_vec("load2", vt[0], 1'b0);
    run_vec("verify_mismatch", vt[1], 1'b0);

    // reset during WR_HI of word 0
    tx.delete();
    tx.push_back(8'h01); tx.push_back(8'h23); tx.push_back(8'h45);
    sb.push_back({12'd0, 18'h12345});
    corrupt_en = 1'b0;
    @(negedge clk);
    start = 1'b1; word_count = 12'd2;
    @(negedge clk);
    start = 1'b0;
    drive_tx(100, acc);
    chk("rstmid_accepted", acc, 3);
    cyc = 0;
    while (!(jtag_clk && jtag_we) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_reach_wr_hi", {30'd0, jtag_clk, jtag_we}, 32'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_flags", {24'd0, s_ready, jtag_rst, jtag_en, jtag_clk, jtag_we, busy, done, error}, 32'd0);
    chk("rstmid_addr_din", {2'd0, jtag_addr, jtag_din}, 32'd0);
    chk("rstmid_err_addr", {20'd0, err_addr}, 32'd0);
    r0 = rises;
    repeat (5) @(negedge clk);
    chk("rstmid_no_clk_edges", rises - r0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec("after_reset", vt[0], 1'b0);

    run_vec("format_err", vt[2], 1'b0);
    run_vec("load4", vt[3], 1'b0);

    // word_count = 0
    r0 = done_cnt;
    @(negedge clk);
    start = 1'b1; word_count = 12'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_next", {29'd0, done, busy, jtag_en}, 32'd4);
    @(negedge clk);
    chk("zero_done_once", {29'd0, done, busy, jtag_en}, 32'd0);
    chk("zero_done_count", done_cnt - r0, 1);

    run_vec("busy_poke", vt[0], 1'b1);
    run_vec("verify_addr0", vt[4], 1'b0);
    run_vec("load1", vt[5], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kcpsm6_rom_loader.md
KCPSM6_ROM_LOADER -- requirements
Module: kcpsm6_rom_loader

Interface
REQ-001 Parameter CLK_HALF, default 2: clk cycles per jtag_clk half-period; legal range 1..15.
REQ-002 clk  in  1  sole clock; all logic on its rising edge; jtag_clk is generated from it.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle load request; ignored while busy=1.
REQ-005 word_count  in  12  number of program words to load; sampled on accepted start.
REQ-006 s_data  in  8  byte stream carrying program words.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_ready  out  1  loader accepts a byte; a transfer occurs when s_valid=1 and s_ready=1.
REQ-009 jtag_rst  out  1  holds the PicoBlaze core in reset (drives rdl_bus).
REQ-010 jtag_en  out  1  program-ROM loader port enable.
REQ-011 jtag_clk  out  1  program-ROM loader port clock.
REQ-012 jtag_addr  out  12  ROM word address.
REQ-013 jtag_din  out  18  instruction word to write.
REQ-014 jtag_we  out  1  ROM write enable.
REQ-015 jtag_dout  in  18  ROM read data, valid after a jtag_clk rising edge.
REQ-016 busy  out  1  load in progress.
REQ-017 done  out  1  one-cycle pulse on successful completion.
REQ-018 error  out  1  sticky load failure; cleared by the next accepted start.
REQ-019 err_addr  out  12  word address at which the failure occurred.

Function
REQ-020 FSM states: IDLE, RECV, WR_LO, WR_HI, RD_LO, RD_HI, CHECK, DONE, FAIL.
REQ-021 IDLE: on start with word_count=0 -> done pulses next cycle, no jtag activity, state stays IDLE.
REQ-022 IDLE: on start with word_count>0 -> RECV; latch count; addr=0; error=0; busy, jtag_en and jtag_rst go 1 next cycle.
REQ-023 RECV: s_ready=1 only in this state; three bytes form one word, big-endian: byte0[1:0]->din[17:16], byte1->din[15:8], byte2->din[7:0].
REQ-024 byte0[7:2] nonzero -> FAIL, err_addr=current addr; remaining bytes of that word are not consumed.
REQ-025 After byte2 accepted -> WR_LO: jtag_din, jtag_addr, jtag_we=1 held stable, jtag_clk=0 for CLK_HALF cycles.
REQ-026 WR_HI: jtag_clk=1 for CLK_HALF cycles with we, addr, din unchanged; then jtag_we=0 -> RD_LO.
REQ-027 RD_LO/RD_HI: jtag_we=0, same addr, jtag_clk low then high for CLK_HALF cycles each; then jtag_clk=0 -> CHECK.
REQ-028 CHECK (1 cycle): jtag_dout == written word -> addr+1; if addr+1 == count -> DONE, else -> RECV; mismatch -> FAIL, err_addr=addr.
REQ-029 jtag_addr increments modulo 4096; count 4096 is not representable (word_count 12 bits, 0 means none).
REQ-030 DONE (1 cycle): done=1, busy=0, jtag_rst=0, jtag_en=0 next cycle; -> IDLE.
REQ-031 FAIL: error=1, busy=0, jtag_en=0, jtag_we=0, jtag_clk=0; jtag_rst stays 1 so the core does not run a partial image; -> IDLE.
REQ-032 After FAIL, jtag_rst stays 1 until the next load ends in DONE.
REQ-033 jtag_we never changes while jtag_clk=1.
REQ-034 jtag_addr and jtag_din never change while jtag_clk=1.
REQ-035 s_valid low in RECV stalls indefinitely; no timeout.
REQ-036 Bytes offered outside RECV are not consumed.
REQ-037 All outputs are registered.

Reset
REQ-038 rst_n=0 forces IDLE asynchronously; error=0, done=0, busy=0, s_ready=0, jtag_en=0, jtag_we=0, jtag_clk=0, jtag_rst=0, jtag_addr=0, jtag_din=0, err_addr=0.
REQ-039 rst_n=0 mid-load abandons the load; no further jtag_clk edges are issued.
REQ-040 rst_n is released synchronously to clk by the instantiating logic.

Verification
REQ-041 Load: word_count=2, bytes 01 23 45, 02 AB CD, ROM model echoes -> writes 0x12345@0 and 0x2ABCD@1, done pulses once, jtag_rst returns to 0, error=0.
REQ-042 Verify mismatch: ROM model returns 0x00000 at addr 1 -> error=1, err_addr=1, jtag_rst stays 1, no done pulse.
REQ-043 Format error: word_count=3, second word's byte0=0x40 -> error=1, err_addr=1, and the following two bytes are not accepted.
REQ-044 Edge case: start with word_count=0 -> done pulses the next cycle, jtag_en stays 0; start pulsed while busy -> ignored and the count is unchanged.
REQ-045 Timing: CLK_HALF=3 with random s_valid gaps -> each jtag_clk high and low phase lasts exactly 3 cycles, and addr/din/we stay stable while jtag_clk=1.
REQ-046 Reset mid-load: rst_n=0 during WR_HI -> all outputs take their reset values immediately, and the next load from address 0 succeeds.
